// File: rtl/parking_time_stamper.sv
// Parking-lot time base and entry/exit timestamp recorder.
// Stores one entry timestamp per slot and, when a car departs, emits the stored
// entry time together with the departure time as a single one-cycle record.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request; an exit request takes priority over an entry request
// ENTRY_WR | write the captured time for the captured slot, or flag err
// EXIT_RD  | read the stored stamp for the captured slot, or flag err
// EXIT_OUT | stamp_valid pulse; free the slot
module parking_time_stamper #(
    parameter int SLOTS    = 8,
    parameter int SLOT_W   = 3,
    parameter int TIME_W   = 8,
    parameter int TICK_DIV = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              entry_valid,
    input  logic [SLOT_W-1:0] entry_slot,
    output logic              entry_ready,
    input  logic              exit_valid,
    input  logic [SLOT_W-1:0] exit_slot,
    output logic              exit_ready,
    output logic [TIME_W-1:0] time_now,
    output logic              stamp_valid,
    output logic [SLOT_W-1:0] stamp_slot,
    output logic [TIME_W-1:0] stamp_time_in,
    output logic [TIME_W-1:0] stamp_time_out,
    output logic [SLOTS-1:0]  occupied,
    output logic              err
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, ENTRY_WR, EXIT_RD, EXIT_OUT} state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [TIME_W-1:0]   tcap_q, tcap_d;
    logic [SLOTS-1:0]    occ_q, occ_d;
    logic [TIME_W-1:0]   mem_q [SLOTS];
    logic [TIME_W-1:0]   mem_d [SLOTS];
    logic [SLOT_W-1:0]   st_slot_q, st_slot_d;
    logic [TIME_W-1:0]   st_in_q, st_in_d;
    logic [TIME_W-1:0]   st_out_q, st_out_d;

    logic                in_range;
    logic                slot_occ;
    logic [TIME_W-1:0]   slot_stamp;
    logic                err_c;
    logic                stamp_valid_c;

    // Prescaler and free-running time counter; time wraps naturally.
    always_comb begin
        pre_d  = pre_q + 1'b1;
        time_d = time_q;
        if (pre_q == PRE_MAX) begin
            pre_d  = '0;
            time_d = time_q + 1'b1;
        end
    end

    // Look up the captured slot; a slot index that matches no entry is out of range.
    always_comb begin
        in_range   = 1'b0;
        slot_occ   = 1'b0;
        slot_stamp = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                in_range   = 1'b1;
                slot_occ   = occ_q[i];
                slot_stamp = mem_q[i];
            end
        end
    end

    // Next-state, slot table updates and record outputs.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        tcap_d        = tcap_q;
        occ_d         = occ_q;
        mem_d         = mem_q;
        st_slot_d     = st_slot_q;
        st_in_d       = st_in_q;
        st_out_d      = st_out_q;
        err_c         = 1'b0;
        stamp_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (exit_valid) begin
                    state_d = EXIT_RD;
                    slot_d  = exit_slot;
                    tcap_d  = time_q;
                end else if (entry_valid) begin
                    state_d = ENTRY_WR;
                    slot_d  = entry_slot;
                    tcap_d  = time_q;
                end
            end
            ENTRY_WR: begin
                state_d = IDLE;
                if (!in_range || slot_occ) begin
                    err_c = 1'b1;
                end else begin
                    for (int i = 0; i < SLOTS; i++) begin
                        if (slot_q == SLOT_W'(i)) begin
                            mem_d[i] = tcap_q;
                            occ_d[i] = 1'b1;
                        end
                    end
                end
            end
            EXIT_RD: begin
                if (!in_range || !slot_occ) begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                end else begin
                    st_slot_d = slot_q;
                    st_in_d   = slot_stamp;
                    st_out_d  = tcap_q;
                    state_d   = EXIT_OUT;
                end
            end
            EXIT_OUT: begin
                stamp_valid_c = 1'b1;
                state_d       = IDLE;
                for (int i = 0; i < SLOTS; i++) begin
                    if (slot_q == SLOT_W'(i)) begin
                        occ_d[i] = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            time_q    <= '0;
            slot_q    <= '0;
            tcap_q    <= '0;
            occ_q     <= '0;
            mem_q     <= '{default: '0};
            st_slot_q <= '0;
            st_in_q   <= '0;
            st_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            time_q    <= time_d;
            slot_q    <= slot_d;
            tcap_q    <= tcap_d;
            occ_q     <= occ_d;
            mem_q     <= mem_d;
            st_slot_q <= st_slot_d;
            st_in_q   <= st_in_d;
            st_out_q  <= st_out_d;
        end
    end

    // Ready lines are forced low while reset is asserted so every output reads 0.
    assign exit_ready     = rst_n & (state_q == IDLE);
    assign entry_ready    = rst_n & (state_q == IDLE) & ~exit_valid;
    assign time_now       = time_q;
    assign stamp_valid    = stamp_valid_c;
    assign stamp_slot     = st_slot_q;
    assign stamp_time_in  = st_in_q;
    assign stamp_time_out = st_out_q;
    assign occupied       = occ_q;
    assign err            = err_c;

endmodule

// File: tb/tb_parking_time_stamper.sv
// Directed bench for parking_time_stamper with TICK_DIV=4 and a 4-bit slot
// index so that out-of-range slot numbers can be presented.
module tb_parking_time_stamper;

    logic       clk;
    logic       rst_n;
    logic       entry_valid;
    logic [3:0] entry_slot;
    logic       entry_ready;
    logic       exit_valid;
    logic [3:0] exit_slot;
    logic       exit_ready;
    logic [7:0] time_now;
    logic       stamp_valid;
    logic [3:0] stamp_slot;
    logic [7:0] stamp_time_in;
    logic [7:0] stamp_time_out;
    logic [7:0] occupied;
    logic       err;

    int total = 0;
    int bad   = 0;

    parking_time_stamper #(
        .SLOTS(8), .SLOT_W(4), .TIME_W(8), .TICK_DIV(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .entry_valid(entry_valid), .entry_slot(entry_slot), .entry_ready(entry_ready),
        .exit_valid(exit_valid), .exit_slot(exit_slot), .exit_ready(exit_ready),
        .time_now(time_now), .stamp_valid(stamp_valid), .stamp_slot(stamp_slot),
        .stamp_time_in(stamp_time_in), .stamp_time_out(stamp_time_out),
        .occupied(occupied), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_time(input logic [7:0] t);
        int n = 0;
        while (time_now != t && n < 1200) begin
            step();
            n++;
        end
        chk("wait_time", time_now, t);
    endtask

    task automatic do_entry(input logic [3:0] s, input logic exp_err);
        entry_valid = 1'b1;
        entry_slot  = s;
        #1;
        chk("entry_ready", entry_ready, 1);
        step();
        entry_valid = 1'b0;
        chk("entry_err", err, exp_err);
        chk("entry_no_stamp", stamp_valid, 0);
        step();
        chk("entry_err_gone", err, 0);
    endtask

    task automatic do_exit(input logic [3:0] s, input logic exp_err,
                           input logic [7:0] exp_in, input logic [7:0] exp_out);
        exit_valid = 1'b1;
        exit_slot  = s;
        #1;
        chk("exit_ready", exit_ready, 1);
        step();
        exit_valid = 1'b0;
        chk("exit_err", err, exp_err);
        chk("exit_sv_n1", stamp_valid, 0);
        step();
        chk("exit_sv_n2", stamp_valid, !exp_err);
        if (!exp_err) begin
            chk("stamp_slot", stamp_slot, s);
            chk("stamp_time_in", stamp_time_in, exp_in);
            chk("stamp_time_out", stamp_time_out, exp_out);
        end
        step();
        chk("exit_sv_n3", stamp_valid, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        entry_valid = 1'b0;
        entry_slot  = '0;
        exit_valid  = 1'b0;
        exit_slot   = '0;
        #12;
        chk("rst_time", time_now, 0);
        chk("rst_occ", occupied, 0);
        chk("rst_exit_ready", exit_ready, 0);
        chk("rst_entry_ready", entry_ready, 0);
        chk("rst_sv", stamp_valid, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Time base: one unit every 4 clocks.
        repeat (3) step();
        chk("tick_3clk", time_now, 0);
        step();
        chk("tick_4clk", time_now, 1);
        repeat (35) step();
        chk("tick_39clk", time_now, 9);
        step();
        chk("tick_40clk", time_now, 10);

        // Wrap 255 -> 0 with nothing else moving.
        wait_time(8'd255);
        begin
            int n = 0;
            while (time_now == 8'd255 && n < 10) begin
                step();
                n++;
            end
        end
        chk("wrap_time", time_now, 0);
        chk("wrap_occ", occupied, 0);
        chk("wrap_sv", stamp_valid, 0);
        chk("wrap_err", err, 0);
        chk("wrap_stamp_in", stamp_time_in, 0);

        // Basic record: slot 2 in at 5, out at 9.
        wait_time(8'd5);
        do_entry(4'd2, 1'b0);
        chk("occ_after_entry2", occupied, 8'h04);
        wait_time(8'd9);
        do_exit(4'd2, 1'b0, 8'd5, 8'd9);
        chk("occ_after_exit2", occupied, 8'h00);
        chk("stamp_slot_hold", stamp_slot, 2);

        // Time wrap between entry and exit.
        wait_time(8'd250);
        do_entry(4'd3, 1'b0);
        chk("occ_after_entry3", occupied, 8'h08);
        wait_time(8'd4);
        do_exit(4'd3, 1'b0, 8'd250, 8'd4);
        chk("wrap_duration", 8'(stamp_time_out - stamp_time_in), 10);

        // Illegal requests.
        wait_time(8'd20);
        do_entry(4'd1, 1'b0);
        chk("occ_entry1", occupied, 8'h02);
        do_entry(4'd1, 1'b1);
        chk("occ_dup_entry1", occupied, 8'h02);
        do_exit(4'd6, 1'b1, 8'd0, 8'd0);
        chk("occ_exit6", occupied, 8'h02);
        do_entry(4'd9, 1'b1);
        chk("occ_entry9", occupied, 8'h02);
        do_exit(4'd9, 1'b1, 8'd0, 8'd0);
        chk("occ_exit9", occupied, 8'h02);
        chk("stamp_in_untouched", stamp_time_in, 250);

        // Simultaneous entry and exit: exit first, entry accepted at N+3.
        wait_time(8'd30);
        exit_valid  = 1'b1;
        exit_slot   = 4'd1;
        entry_valid = 1'b1;
        entry_slot  = 4'd4;
        #1;
        chk("sim_exit_ready", exit_ready, 1);
        chk("sim_entry_ready", entry_ready, 0);
        step();
        exit_valid = 1'b0;
        #1;
        chk("sim_n1_entry_ready", entry_ready, 0);
        step();
        chk("sim_n2_sv", stamp_valid, 1);
        chk("sim_n2_slot", stamp_slot, 1);
        chk("sim_n2_in", stamp_time_in, 20);
        chk("sim_n2_out", stamp_time_out, 30);
        chk("sim_n2_entry_ready", entry_ready, 0);
        step();
        chk("sim_n3_entry_ready", entry_ready, 1);
        chk("sim_n3_occ", occupied, 8'h00);
        step();
        entry_valid = 1'b0;
        chk("sim_entry_err", err, 0);
        step();
        chk("sim_occ_entry4", occupied, 8'h10);

        // Reset while in EXIT_RD.
        exit_valid = 1'b1;
        exit_slot  = 4'd4;
        step();
        exit_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("mid_rst_sv", stamp_valid, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_occ", occupied, 0);
        chk("mid_rst_time", time_now, 0);
        chk("mid_rst_slot", stamp_slot, 0);
        chk("mid_rst_in", stamp_time_in, 0);
        chk("mid_rst_out", stamp_time_out, 0);
        chk("mid_rst_exit_ready", exit_ready, 0);
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_sv", stamp_valid, 0);
            chk("post_rst_err", err, 0);
        end
        chk("post_rst_exit_ready", exit_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
